spi_frame_rx: RTL

//  Parametrised SPI slave frame receiver, system-clock domain. Synchronises SPI_CLK/SPI_CS/SPI_DATA,

---
 rtl/spi_frame_rx.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/spi_frame_rx.sv
// SPI slave frame receiver: synchronised SCK/CS/DATA, MSB-first shift, length check, valid/ready output.
// Define SPI_FIFO_EN to replace the single holding register with a FIFO_DEPTH-entry FWFT FIFO.
module spi_frame_rx #(
   parameter int FRAME_BITS  = 24,
   parameter int SYNC_STAGES = 2,
   parameter int SAMPLE_EDGE = 0,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                               CLOCK_50,
   input  logic                               RESET_N,
   input  logic                               SPI_CLK,
   input  logic                               SPI_CS,
   input  logic                               SPI_DATA,
   output logic [FRAME_BITS-1:0]              frame_data,
   output logic                               frame_valid,
   input  logic                               frame_ready,
   output logic                               frame_err,
   output logic                               overrun,
   output logic                               busy,
   output logic [15:0]                        frame_count,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);
   localparam int LW = $clog2(FIFO_DEPTH + 1);
   localparam int CW = $clog2(FRAME_BITS + 2);
   localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
   localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_BITS + 1);

   logic [SYNC_STAGES-1:0] r_cs_sync, r_sck_sync, r_dat_sync;
   logic                   r_cs_d, r_sck_d;
   logic [FRAME_BITS-1:0]  r_shift;
   logic [CW-1:0]          r_cnt;
   logic                   r_busy, r_err, r_overrun;
   logic [15:0]            r_count;

   logic w_cs_s, w_sck_s, w_dat_s, w_cs_fall, w_cs_rise, w_sck_edge, w_commit;

   // CS idles high so a reset never fabricates a chip-select fall.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         r_cs_sync  <= '1;
         r_sck_sync <= '0;
         r_dat_sync <= '0;
         r_cs_d     <= 1'b1;
         r_sck_d    <= 1'b0;
      end else begin
         r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], SPI_CS};
         r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], SPI_CLK};
         r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], SPI_DATA};
         r_cs_d     <= w_cs_s;
         r_sck_d    <= w_sck_s;
      end
   end

   assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
   assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
   assign w_dat_s    = r_dat_sync[SYNC_STAGES-1];
   assign w_cs_fall  = r_cs_d & ~w_cs_s;
   assign w_cs_rise  = ~r_cs_d & w_cs_s;
   assign w_sck_edge = (SAMPLE_EDGE != 0) ? (~r_sck_d & w_sck_s) : (r_sck_d & ~w_sck_s);
   assign w_commit   = w_cs_rise & (r_cnt == CNT_FULL);

   // A CS rise takes priority over a coincident SCK edge, which is dropped.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         r_shift <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_err   <= 1'b0;
         r_count <= '0;
      end else begin
         r_busy <= ~w_cs_s;
         r_err  <= w_cs_rise & (r_cnt != CNT_FULL);
         if (w_commit)
            r_count <= r_count + 16'd1;
         if (w_cs_fall) begin
            r_shift <= '0;
            r_cnt   <= '0;
         end else if (!w_cs_rise && w_sck_edge && !w_cs_s) begin
            r_shift <= {r_shift[FRAME_BITS-2:0], w_dat_s};
            if (r_cnt != CNT_SAT)
               r_cnt <= r_cnt + CW'(1);
         end
      end
   end

`ifdef SPI_FIFO_EN
   localparam int PW = $clog2(FIFO_DEPTH);

   logic [FRAME_BITS-1:0] r_mem [FIFO_DEPTH];
   logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
   logic [LW-1:0]         r_level;
   logic                  w_pop, w_push, w_full;

   assign w_full = (r_level == LW'(FIFO_DEPTH));
   assign w_pop  = (r_level != '0) & frame_ready;
   assign w_push = w_commit & (~w_full | w_pop);

   always_ff @(posedge CLOCK_50) begin
      if (w_push)
         r_mem[r_wr_ptr] <= r_shift;
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_level   <= '0;
         r_overrun <= 1'b0;
      end else begin
         r_overrun <= w_commit & w_full & ~w_pop;
         if (w_push)
            r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + PW'(1);
         r_level <= r_level + LW'(w_push) - LW'(w_pop);
      end
   end

   // Memory is not reset, so the head is masked while empty.
   assign frame_valid = (r_level != '0);
   assign frame_data  = frame_valid ? r_mem[r_rd_ptr] : '0;
   assign fifo_level  = r_level;
`else
   logic [FRAME_BITS-1:0] r_hold;
   logic                  r_valid;

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         r_hold    <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_overrun <= w_commit & r_valid & ~frame_ready;
         if (w_commit) begin
            r_hold  <= r_shift;
            r_valid <= 1'b1;
         end else if (r_valid && frame_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign frame_valid = r_valid;
   assign frame_data  = r_hold;
   assign fifo_level  = LW'(r_valid);
`endif

   assign frame_err   = r_err;
   assign overrun     = r_overrun;
   assign busy        = r_busy;
   assign frame_count = r_count;
endmodule
